// File: rtl/inst_issue_if.sv
// Instruction-issue bus between a controller and the inst_issue sequencer.
//   prog_v/prog_inst/prog_clr : program-buffer load and clear
//   start/hold                : run control (one-cycle start pulse, issue stall)
//   inst_v/inst               : registered instruction stream toward the PE decoders
//   busy/done                 : run status (done is a one-cycle pulse)
//   prog_cnt/prog_full        : program-buffer fill level
// Modport slave is the sequencer side, master the controller side.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface inst_issue_if #(
    parameter int unsigned DEPTH = 16
);
    logic                     prog_v;
    logic [`INST_WIDTH-1:0]   prog_inst;
    logic                     prog_clr;
    logic                     start;
    logic                     hold;
    logic                     inst_v;
    logic [`INST_WIDTH-1:0]   inst;
    logic                     busy;
    logic                     done;
    logic [$clog2(DEPTH):0]   prog_cnt;
    logic                     prog_full;

    modport master (
        output prog_v, prog_inst, prog_clr, start, hold,
        input  inst_v, inst, busy, done, prog_cnt, prog_full
    );

    modport slave (
        input  prog_v, prog_inst, prog_clr, start, hold,
        output inst_v, inst, busy, done, prog_cnt, prog_full
    );
endinterface

// File: rtl/inst_issue.sv
// Program buffer plus issue sequencer. Instructions are loaded into a DEPTH-slot
// buffer, then on start each slot is issued inst[7:0]+1 times in order, followed by
// DRAIN idle cycles for the PE pipeline to write back, and a one-cycle done pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts a run without a done pulse
//   bus  : inst_issue_if slave modport (program load, run control, issue stream)
// DEPTH must be a power of two >= 2; DRAIN must be >= 1.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_issue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DRAIN = 6
) (
    input logic         clk,
    input logic         rst,
    inst_issue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0] DrainLast = DW'(DRAIN - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

    logic [`INST_WIDTH-1:0] mem_q [DEPTH];

    state_e                 state_q;
    logic [CW-1:0]          pc_q;
    logic [7:0]             rpt_q;
    logic [CW-1:0]          len_q;
    logic [CW-1:0]          cnt_q;
    logic [DW-1:0]          drain_q;
    logic                   inst_v_q;
    logic [`INST_WIDTH-1:0] inst_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   full;
    logic                   start_ok;
    logic                   clr_ok;
    logic                   wr_ok;
    logic                   issue_fire;
    logic [CW-1:0]          iss_pc;
    logic [CW-1:0]          iss_len;
    logic [CW-1:0]          iss_pc_nxt;
    logic [7:0]             iss_rpt;
    logic [7:0]             iss_rpt_nxt;
    logic [`INST_WIDTH-1:0] iss_word;
    logic                   iss_last_rpt;
    logic                   iss_final;

    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        // busy_q also covers the done cycle, so start there is ignored
        start_ok = bus.start && (state_q == StIdle) && !busy_q;
        clr_ok   = bus.prog_clr && !busy_q;
        wr_ok    = bus.prog_v && !busy_q && !full && !bus.prog_clr;

        // The accepted start edge already issues slot 0 so inst_v appears one cycle
        // later; pc/rpt therefore always point at the next word to issue.
        iss_pc       = (state_q == StIdle) ? '0 : pc_q;
        iss_rpt      = (state_q == StIdle) ? '0 : rpt_q;
        iss_len      = (state_q == StIdle) ? cnt_q : len_q;
        iss_word     = mem_q[iss_pc[AW-1:0]];
        iss_last_rpt = (iss_rpt == iss_word[7:0]);
        iss_pc_nxt   = iss_last_rpt ? iss_pc + CW'(1) : iss_pc;
        iss_rpt_nxt  = iss_last_rpt ? 8'd0 : iss_rpt + 8'd1;
        iss_final    = iss_last_rpt && (iss_pc == iss_len - CW'(1));

        issue_fire = (start_ok && (cnt_q != '0)) || ((state_q == StIssue) && !bus.hold);
    end

    // Buffer contents survive reset and prog_clr; only the count is cleared.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[cnt_q[AW-1:0]] <= bus.prog_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            rpt_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
            inst_v_q <= 1'b0;
            inst_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inst_v_q <= 1'b0;
            done_q   <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end

            if (clr_ok) begin
                cnt_q <= '0;
            end else if (wr_ok) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // Latch the length so a write in the start cycle does not extend the run.
            if (start_ok) begin
                busy_q <= 1'b1;
                len_q  <= cnt_q;
            end

            if (issue_fire) begin
                inst_q   <= iss_word;
                inst_v_q <= 1'b1;
                pc_q     <= iss_pc_nxt;
                rpt_q    <= iss_rpt_nxt;
                drain_q  <= '0;
                state_q  <= iss_final ? StDrain : StIssue;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_ok) begin
                            state_q <= StFin;
                        end
                    end
                    StIssue: begin
                        // hold: inst_v drops, pc/rpt/inst stay put
                    end
                    StDrain: begin
                        if (drain_q == DrainLast) begin
                            state_q <= StFin;
                        end else begin
                            drain_q <= drain_q + DW'(1);
                        end
                    end
                    StFin: begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                        pc_q    <= '0;
                        rpt_q   <= '0;
                        drain_q <= '0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.inst_v    = inst_v_q;
    assign bus.inst      = inst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.prog_cnt  = cnt_q;
    assign bus.prog_full = full;
endmodule
